// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard sequencer: load-use stall, branch flush, mul/div freeze, forwarding (optional HAZ_PERF_EN counters)
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] exe_rs1_addr,
    input  logic [4:0] exe_rs2_addr,
    input  logic [4:0] exe_rd_addr,
    input  logic       exe_mem_read,
    input  logic       exe_md_start,
    input  logic       next_pc_sel,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_reg_write,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_exe_hold,
    output logic       id_exe_flush,
    output logic       exe_mem_flush,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       md_busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] md_count
`endif
);

    localparam logic RUN     = 1'b0;
    localparam logic MD_WAIT = 1'b1;

    localparam bit              MD_EN   = (MD_LAT >= 2);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_EN ? MD_LAT - 2 : 0);

    logic             state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             md_enter;

    always_comb begin
        load_use = exe_mem_read && (exe_rd_addr != 5'd0) &&
                   ((id_rs1_used && (id_rs1_addr == exe_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == exe_rd_addr)));
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_hold   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        md_busy       = 1'b0;
        md_enter      = 1'b0;
        case (state)
            RUN: begin
                // A taken branch flushes the dependent instruction, so it outranks md/load-use.
                if (next_pc_sel) begin
                    if_id_flush  = 1'b1;
                    id_exe_flush = 1'b1;
                end else if (exe_md_start && MD_EN) begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_exe_hold   = 1'b1;
                    exe_mem_flush = 1'b1;
                    cnt_nxt       = MD_LOAD;
                    state_nxt     = MD_WAIT;
                    md_enter      = 1'b1;
                end else if (load_use) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_exe_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (cnt != '0) begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_exe_hold   = 1'b1;
                    exe_mem_flush = 1'b1;
                    cnt_nxt       = cnt - CNT_W'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       m_we,
                                           input logic [4:0] m_rd,
                                           input logic       w_we,
                                           input logic [4:0] w_rd);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return 2'd1;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        fwd_rs1_sel = fwd_sel(exe_rs1_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
        fwd_rs2_sel = fwd_sel(exe_rs2_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
            md_count     <= 32'd0;
        end else begin
            if (pc_hold)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)
                flush_count <= flush_count + 32'd1;
            if (md_enter)
                md_count <= md_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MD_LAT=4)
module tb_hazard_ctrl;
    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, exe_rs1_addr, exe_rs2_addr, exe_rd_addr;
    logic [4:0] mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, exe_mem_read, exe_md_start, next_pc_sel;
    logic       mem_reg_write, wb_reg_write;
    logic       pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_flush, md_busy;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_count, md_count;
`endif

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rs1_addr(exe_rs1_addr), .exe_rs2_addr(exe_rs2_addr),
        .exe_rd_addr(exe_rd_addr), .exe_mem_read(exe_mem_read),
        .exe_md_start(exe_md_start), .next_pc_sel(next_pc_sel),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_exe_hold(id_exe_hold), .id_exe_flush(id_exe_flush),
        .exe_mem_flush(exe_mem_flush),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .md_busy(md_busy)
`ifdef HAZ_PERF_EN
        ,
        .stall_cycles(stall_cycles), .flush_count(flush_count), .md_count(md_count)
`endif
    );

    always #5 clk = ~clk;

    // {pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_flush, md_busy, fwd1, fwd2}
    localparam logic [31:0] E_NONE = 32'h000;
    localparam logic [31:0] E_LU   = 32'h640;
    localparam logic [31:0] E_BR   = 32'h140;
    localparam logic [31:0] E_MD   = 32'h6A0;
    localparam logic [31:0] E_MDB  = 32'h6B0;
    localparam logic [31:0] E_BUSY = 32'h010;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] obs();
        return {21'd0, pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush,
                exe_mem_flush, md_busy, fwd_rs1_sel, fwd_rs2_sel};
    endfunction

    task automatic clear_inputs();
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        exe_rs1_addr = 0; exe_rs2_addr = 0; exe_rd_addr = 0;
        exe_mem_read = 0; exe_md_start = 0; next_pc_sel = 0;
        mem_rd_addr = 0; mem_reg_write = 0; wb_rd_addr = 0; wb_reg_write = 0;
    endtask

    task automatic expect_now(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        exe_mem_read = 1; exe_rd_addr = rd; id_rs2_used = 1; id_rs2_addr = 5'd5;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        clear_inputs();
        rst = 1'b1;
        #2;
        expect_now("reset_hold", E_NONE);
        #1;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        next_cycle();
        rst = 1'b0;
        // enter MD_WAIT, then reset asynchronously mid-cycle
        exe_md_start = 1;
        next_cycle();
        #3;
        expect_now("md_busy_before_reset", E_MDB);
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        rst = 1'b1;
        exe_md_start = 0;
        expect_now("async_reset_mid_md", E_NONE);
        #1;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        expect_now("run_after_reset", E_NONE);
        #2;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        next_cycle();
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [31:0] got;
        string names[5] = '{"lu_rs2", "lu_cleared", "lu_rd0", "lu_rs1", "lu_unused_src"};
        logic [31:0] exps[5] = '{E_LU, E_NONE, E_NONE, E_LU, E_NONE};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: set_load_use(5'd5);
                2: set_load_use(5'd0);
                3: begin exe_mem_read = 1; exe_rd_addr = 5'd12; id_rs1_used = 1; id_rs1_addr = 5'd12; end
                4: begin set_load_use(5'd5); id_rs2_used = 0; end
                default: ;
            endcase
            expect_now(names[i], exps[i]);
            #2;
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
            next_cycle();
        end
    endtask

    task automatic test_branch_priority();
        exp_t e;
        logic [31:0] got;
        clear_inputs();
        set_load_use(5'd5);
        next_pc_sel = 1;
        exe_md_start = 1;
        expect_now("branch_over_md_and_lu", E_BR);
        #2;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        next_cycle();
        clear_inputs();
        set_load_use(5'd5);
        expect_now("lu_after_branch", E_LU);
        #2;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        next_cycle();
    endtask

    task automatic test_muldiv();
        exp_t e;
        logic [31:0] got;
        clear_inputs();
        for (int t = 0; t <= MD_LAT; t++) begin
            exe_md_start = (t < MD_LAT);
            next_pc_sel  = (t == 1);
            if (t == 0)               expect_now("md_T", E_MD);
            else if (t < MD_LAT - 1)  expect_now($sformatf("md_T+%0d", t), E_MDB);
            else if (t == MD_LAT - 1) expect_now("md_release", E_BUSY);
            else                      expect_now("md_back_to_run", E_NONE);
            #2;
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [31:0] got;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            mem_reg_write = 1; wb_reg_write = 1;
            case (i)
                0: begin exe_rs1_addr = 7; mem_rd_addr = 7; wb_rd_addr = 7; expect_now("fwd_mem_wins", 32'h004); end
                1: begin exe_rs1_addr = 7; mem_rd_addr = 7; wb_rd_addr = 7; mem_reg_write = 0; expect_now("fwd_wb", 32'h008); end
                2: begin expect_now("fwd_x0", 32'h000); end
                3: begin exe_rs1_addr = 7; exe_rs2_addr = 3; mem_rd_addr = 7; wb_rd_addr = 3; expect_now("fwd_split", 32'h006); end
                default: begin exe_rs2_addr = 9; mem_rd_addr = 9; wb_rd_addr = 9; mem_reg_write = 0; wb_reg_write = 0; expect_now("fwd_no_we", 32'h000); end
            endcase
            #2;
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
            next_cycle();
        end
        clear_inputs();
    endtask

`ifdef HAZ_PERF_EN
    task automatic test_perf();
        exp_t e;
        logic [31:0] got;
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_load_use(5'd5);
        next_cycle();
        clear_inputs();
        next_pc_sel = 1;
        next_cycle();
        clear_inputs();
        exe_md_start = 1;
        repeat (MD_LAT) next_cycle();
        clear_inputs();
        next_cycle();
        expect_now("perf_stall_cycles", 32'd4);
        expect_now("perf_flush_count", 32'd1);
        expect_now("perf_md_count", 32'd1);
        for (int k = 0; k < 3; k++) begin
            got = (k == 0) ? stall_cycles : (k == 1) ? flush_count : md_count;
            e = exp_q.pop_front(); checks++;
            if (got !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, got, e.val); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_muldiv();
        test_forwarding();
`ifdef HAZ_PERF_EN
        test_perf();
`endif
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
